// File: rtl/board_store.sv
// Chess board store: 64 x 4-bit squares, row-wise init, capture and game-over tracking.
// Optional capture counters are built when CAPTURE_COUNT_EN is defined.
module board_store (
    input  logic         clk,
    input  logic         reset,
    input  logic [10:0]  changePiece,
    input  logic [2:0]   currentState,
    output logic [255:0] entireBoard,
    output logic         boardReady,
    output logic         capturePulse,
    output logic [3:0]   capturedPiece,
    output logic         gameOver,
    output logic [4:0]   whiteCaptures,
    output logic [4:0]   blackCaptures
);

    typedef enum logic [1:0] {
        S_INIT,
        S_READY,
        S_OVER
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     row_q, row_d;
    logic [2:0]     prev_q;
    logic [255:0]   board_q, board_d;
    logic           pulse_q, pulse_d;
    logic [3:0]     capt_q, capt_d;

    logic [5:0]     wr_addr;
    logic [3:0]     wr_code;
    logic [3:0]     old_code;
    logic           start_game;
    logic           wr_ok;
    logic           is_cap;

    function automatic logic [31:0] row_layout(input logic [2:0] r);
        logic [31:0] v;
        v = 32'h0;
        case (r)
            3'd0:    v = 32'hCABE_DBAC;
            3'd1:    v = 32'h9999_9999;
            3'd6:    v = 32'h1111_1111;
            3'd7:    v = 32'h4236_5324;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    assign wr_addr    = changePiece[5:0];
    assign wr_code    = changePiece[9:6];
    assign old_code   = board_q[{wr_addr, 2'b00} +: 4];
    assign start_game = (prev_q != 3'b000) && (currentState == 3'b000);
    assign wr_ok      = (state_q == S_READY) && !start_game &&
                        changePiece[10] && (wr_code[2:0] != 3'd7);
    // Capture needs two non-empty pieces of opposite colour.
    assign is_cap     = wr_ok && (wr_code[2:0] != 3'd0) &&
                        (old_code[2:0] != 3'd0) && (wr_code[3] != old_code[3]);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        board_d = board_q;
        pulse_d = 1'b0;
        capt_d  = capt_q;
        if (start_game) begin
            state_d = S_INIT;
            row_d   = 3'd0;
            capt_d  = 4'd0;
        end else begin
            case (state_q)
                S_INIT: begin
                    board_d[{row_q, 5'b00000} +: 32] = row_layout(row_q);
                    row_d = row_q + 3'd1;
                    if (row_q == 3'd7) state_d = S_READY;
                end
                S_READY: begin
                    if (wr_ok) board_d[{wr_addr, 2'b00} +: 4] = wr_code;
                    if (is_cap) begin
                        pulse_d = 1'b1;
                        capt_d  = old_code;
                        if (old_code[2:0] == 3'd6) state_d = S_OVER;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            row_q   <= 3'd0;
            prev_q  <= 3'b000;
            board_q <= '0;
            pulse_q <= 1'b0;
            capt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            prev_q  <= currentState;
            board_q <= board_d;
            pulse_q <= pulse_d;
            capt_q  <= capt_d;
        end
    end

`ifdef CAPTURE_COUNT_EN
    logic [4:0] wcnt_q, wcnt_d;
    logic [4:0] bcnt_q, bcnt_d;

    // Saturate at 16: a side never loses more than 16 pieces.
    always_comb begin
        wcnt_d = wcnt_q;
        bcnt_d = bcnt_q;
        if (start_game) begin
            wcnt_d = 5'd0;
            bcnt_d = 5'd0;
        end else if (is_cap) begin
            if (old_code[3] && bcnt_q < 5'd16) bcnt_d = bcnt_q + 5'd1;
            if (!old_code[3] && wcnt_q < 5'd16) wcnt_d = wcnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= 5'd0;
            bcnt_q <= 5'd0;
        end else begin
            wcnt_q <= wcnt_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign whiteCaptures = wcnt_q;
    assign blackCaptures = bcnt_q;
`else
    assign whiteCaptures = 5'd0;
    assign blackCaptures = 5'd0;
`endif

    assign entireBoard   = board_q;
    assign boardReady    = (state_q == S_READY);
    assign gameOver      = (state_q == S_OVER);
    assign capturePulse  = pulse_q;
    assign capturedPiece = capt_q;

endmodule

// File: tb/tb_board_store.sv
// Directed self-checking bench for board_store.
module tb_board_store;

    logic         clk = 1'b0;
    logic         reset;
    logic [10:0]  changePiece;
    logic [2:0]   currentState;
    logic [255:0] entireBoard;
    logic         boardReady;
    logic         capturePulse;
    logic [3:0]   capturedPiece;
    logic         gameOver;
    logic [4:0]   whiteCaptures;
    logic [4:0]   blackCaptures;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CAPTURE_COUNT_EN
    localparam logic [4:0] ONE_CAP = 5'd1;
`else
    localparam logic [4:0] ONE_CAP = 5'd0;
`endif

    board_store dut (
        .clk           (clk),
        .reset         (reset),
        .changePiece   (changePiece),
        .currentState  (currentState),
        .entireBoard   (entireBoard),
        .boardReady    (boardReady),
        .capturePulse  (capturePulse),
        .capturedPiece (capturedPiece),
        .gameOver      (gameOver),
        .whiteCaptures (whiteCaptures),
        .blackCaptures (blackCaptures)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] sq(input int i);
        return entireBoard[4*i +: 4];
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] code, input logic [5:0] addr);
        changePiece = {1'b1, code, addr};
    endtask

    initial begin
        reset        = 1'b1;
        changePiece  = '0;
        currentState = 3'b000;
        tick(1);
        chk("rst_board", entireBoard, '0);
        chk("rst_ready", boardReady, 0);
        chk("rst_pulse", capturePulse, 0);
        chk("rst_capt", capturedPiece, 0);
        chk("rst_over", gameOver, 0);
        chk("rst_bcnt", blackCaptures, 0);

        reset = 1'b0;
        tick(7);
        chk("init_notready", boardReady, 0);
        tick(1);
        chk("init_ready", boardReady, 1);
        chk("sq4_bk", sq(4), 4'b1110);
        chk("sq60_wk", sq(60), 4'b0110);
        chk("sq52_wp", sq(52), 4'b0001);
        chk("sq32_empty", sq(32), 4'b0000);
        chk("sq0_br", sq(0), 4'b1100);
        chk("sq63_wr", sq(63), 4'b0100);

        wr(4'b0001, 6'd36);
        tick(1);
        chk("mv_sq36", sq(36), 4'b0001);
        chk("mv_pulse1", capturePulse, 0);
        wr(4'b0000, 6'd52);
        tick(1);
        chk("mv_sq52", sq(52), 4'b0000);
        chk("mv_pulse2", capturePulse, 0);

        wr(4'b0101, 6'd11);
        tick(1);
        chk("cap_pulse", capturePulse, 1);
        chk("cap_piece", capturedPiece, 4'b1001);
        chk("cap_sq11", sq(11), 4'b0101);
        chk("cap_bcnt", blackCaptures, ONE_CAP);
        chk("cap_wcnt", whiteCaptures, 0);
        tick(1);
        chk("hold_pulse", capturePulse, 0);
        chk("hold_piece", capturedPiece, 4'b1001);
        chk("hold_bcnt", blackCaptures, ONE_CAP);

        wr(4'b0111, 6'd32);
        tick(1);
        chk("illegal_sq32", sq(32), 4'b0000);

        wr(4'b0001, 6'd56);
        tick(1);
        chk("own_sq56", sq(56), 4'b0001);
        chk("own_pulse", capturePulse, 0);

        wr(4'b0101, 6'd4);
        tick(1);
        chk("king_pulse", capturePulse, 1);
        chk("king_piece", capturedPiece, 4'b1110);
        chk("king_over", gameOver, 1);
        chk("king_notready", boardReady, 0);
        wr(4'b0001, 6'd20);
        tick(1);
        chk("over_sq20", sq(20), 4'b0000);
        chk("over_pulse", capturePulse, 0);
        changePiece = '0;

        currentState = 3'b001;
        tick(1);
        chk("over_hold", gameOver, 1);
        currentState = 3'b000;
        tick(1);
        chk("start_over", gameOver, 0);
        chk("start_ready", boardReady, 0);
        chk("start_capt", capturedPiece, 0);
        chk("start_bcnt", blackCaptures, 0);
        tick(7);
        chk("re_notready", boardReady, 0);
        tick(1);
        chk("re_ready", boardReady, 1);
        chk("re_sq4", sq(4), 4'b1110);
        chk("re_sq11", sq(11), 4'b1001);
        chk("re_sq56", sq(56), 4'b0100);
        chk("re_sq36", sq(36), 4'b0000);
        tick(10);
        chk("hold000_ready", boardReady, 1);

        currentState = 3'b010;
        tick(1);
        currentState = 3'b000;
        tick(4);
        currentState = 3'b011;
        tick(1);
        currentState = 3'b000;
        tick(1);
        tick(7);
        chk("restart_notready", boardReady, 0);
        tick(1);
        chk("restart_ready", boardReady, 1);

        wr(4'b0101, 6'd11);
        reset = 1'b1;
        tick(1);
        chk("midrst_board", entireBoard, '0);
        chk("midrst_pulse", capturePulse, 0);
        chk("midrst_capt", capturedPiece, 0);
        chk("midrst_ready", boardReady, 0);
        reset       = 1'b0;
        changePiece = '0;
        tick(8);
        chk("midrst_back", boardReady, 1);
        chk("midrst_sq11", sq(11), 4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
